// File: rtl/sharp_lcd_pkg.sv
// Shared types for the Sharp memory-LCD double framebuffer: pixel/word types,
// write FSM states and the pixel-pair packing helper.
package sharp_lcd_pkg;

  typedef logic [5:0]  rgb222_t;
  typedef logic [15:0] pixel_pair_word_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DONE
  } wr_state_t;

  localparam logic [1:0] PIXEL_PAD = 2'b00;

  function automatic pixel_pair_word_t pack_pair(input rgb222_t even_pix, input rgb222_t odd_pix);
    return {PIXEL_PAD, even_pix, PIXEL_PAD, odd_pix};
  endfunction

endpackage

// File: rtl/sharp_lcd_double_framebuffer_if.sv
// Producer write stream plus display-driver read/vsync bundle of the framebuffer.
interface sharp_lcd_double_framebuffer_if #(
  parameter int ADDR_WIDTH = 16
);
  import sharp_lcd_pkg::*;

  logic                  wr_valid_i;
  logic                  wr_ready_o;
  logic                  wr_sof_i;
  rgb222_t               wr_pixel_i;
  logic                  vsync_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic                  read_valid_i;
  pixel_pair_word_t      pixel_data_o;
  logic                  front_bank_o;
  logic                  frame_swapped_o;

  modport slave (
    input  wr_valid_i, wr_sof_i, wr_pixel_i, vsync_i, addr_i, read_valid_i,
    output wr_ready_o, pixel_data_o, front_bank_o, frame_swapped_o
  );

  modport master (
    output wr_valid_i, wr_sof_i, wr_pixel_i, vsync_i, addr_i, read_valid_i,
    input  wr_ready_o, pixel_data_o, front_bank_o, frame_swapped_o
  );

endinterface

// File: rtl/sharp_lcd_bank_ram.sv
// Simple dual-port RAM holding both frame banks: one write port, one registered read port.
module sharp_lcd_bank_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Bank bit sits above the word index, so the depth is the full address space.
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sharp_lcd_double_framebuffer.sv
// Double-buffered RGB222 frame store: packs pixel pairs into the back bank and
// swaps banks on a driver vsync rising edge once the back frame is complete.
module sharp_lcd_double_framebuffer
  import sharp_lcd_pkg::*;
#(
  parameter int H_PIXELS   = 240,
  parameter int V_LINES    = 240,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  sharp_lcd_double_framebuffer_if.slave bus
);

  localparam int FRAME_WORDS  = H_PIXELS * V_LINES / 2;
  localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
  localparam int WORD_W       = $clog2(FRAME_WORDS);
  localparam int PIX_W        = WORD_W + 1;
  localparam int BANK_AW      = WORD_W + 1;

  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(FRAME_WORDS - 1);

  function automatic logic [PIX_W-1:0] sat_inc(input logic [PIX_W-1:0] v);
    return (v == LAST_PIX) ? v : v + PIX_W'(1);
  endfunction

  wr_state_t          state_q, state_n;
  // Index of the next pixel expected in the current frame.
  logic [PIX_W-1:0]   pix_idx_q, pix_idx_n;
  rgb222_t            hold_q;
  logic               hold_ld;
  logic               ram_we, ram_re;
  logic [BANK_AW-1:0] ram_waddr, ram_raddr;
  pixel_pair_word_t   ram_wdata, ram_rdata;
  logic               vsync_q, front_bank_q, front_valid_q, swapped_q, wr_ready_q;
  logic               rd_zero_p1;
  logic               accept, vsync_rise, swap, rd_in_range;

  assign accept      = bus.wr_valid_i & wr_ready_q;
  assign vsync_rise  = bus.vsync_i & ~vsync_q;
  assign swap        = vsync_rise & (state_q == W_DONE);
  assign rd_in_range = (32'(bus.addr_i) < 32'(FRAME_WORDS));

  always_comb begin
    state_n   = state_q;
    pix_idx_n = pix_idx_q;
    hold_ld   = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      W_IDLE: begin
        if (accept && bus.wr_sof_i) begin
          state_n   = W_FILL;
          hold_ld   = 1'b1;
          pix_idx_n = PIX_W'(1);
        end
      end
      W_FILL: begin
        if (accept) begin
          if (bus.wr_sof_i) begin
            hold_ld   = 1'b1;
            pix_idx_n = PIX_W'(1);
          end else if (!pix_idx_q[0]) begin
            hold_ld   = 1'b1;
            pix_idx_n = sat_inc(pix_idx_q);
          end else begin
            ram_we = 1'b1;
            if (pix_idx_q[PIX_W-1:1] == LAST_WORD) state_n = W_DONE;
            else                                   pix_idx_n = sat_inc(pix_idx_q);
          end
        end
      end
      W_DONE: begin
        if (swap) state_n = W_IDLE;
      end
      default: state_n = W_IDLE;
    endcase
  end

  assign ram_waddr = {~front_bank_q, pix_idx_q[PIX_W-1:1]};
  assign ram_wdata = pack_pair(hold_q, bus.wr_pixel_i);
  assign ram_re    = bus.read_valid_i & rd_in_range;
  assign ram_raddr = {front_bank_q, bus.addr_i[WORD_W-1:0]};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= W_IDLE;
      pix_idx_q     <= '0;
      vsync_q       <= 1'b0;
      front_bank_q  <= 1'b0;
      front_valid_q <= 1'b0;
      swapped_q     <= 1'b0;
      wr_ready_q    <= 1'b0;
      rd_zero_p1    <= 1'b1;
    end else begin
      state_q    <= state_n;
      pix_idx_q  <= pix_idx_n;
      vsync_q    <= bus.vsync_i;
      swapped_q  <= swap;
      wr_ready_q <= (state_n != W_DONE);
      if (swap) begin
        front_bank_q  <= ~front_bank_q;
        front_valid_q <= 1'b1;
      end
      // p0 -> p1: read result is forced to zero until a frame has been shown.
      if (bus.read_valid_i) rd_zero_p1 <= ~(front_valid_q & rd_in_range);
    end
  end

  always_ff @(posedge clk_i) begin
    if (hold_ld) hold_q <= bus.wr_pixel_i;
  end

  sharp_lcd_bank_ram #(
    .DATA_W(16),
    .ADDR_W(BANK_AW)
  ) u_bank_ram (
    .clk  (clk_i),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign bus.wr_ready_o      = wr_ready_q;
  assign bus.pixel_data_o    = rd_zero_p1 ? '0 : ram_rdata;
  assign bus.front_bank_o    = front_bank_q;
  assign bus.frame_swapped_o = swapped_q;

endmodule
